chan_sel_bin_extract: RTL and testbench

//   Downstream consumer of the ch_bin3 software register in the chan_sel path. It extracts one channel

---
 rtl/chan_sel_bin_extract_if.sv | 26 ++
 rtl/chan_sel_bin_extract.sv | 123 ++++++++++++
 tb/tb_chan_sel_bin_extract.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/chan_sel_bin_extract_if.sv
// Channelized I/Q stream in, single selected channel out.
interface chan_sel_bin_extract_if #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned N_LANES = 4,
   parameter int unsigned CH_W    = 10
);
   logic                        in_sync;
   logic [N_LANES*DATA_W-1:0]   in_i;
   logic [N_LANES*DATA_W-1:0]   in_q;
   logic [DATA_W-1:0]           out_i;
   logic [DATA_W-1:0]           out_q;
   logic                        out_valid;
   logic [CH_W-1:0]             out_ch;
   logic                        out_sync;
   logic                        sync_err;

   modport master (
      output in_sync, in_i, in_q,
      input  out_i, out_q, out_valid, out_ch, out_sync, sync_err
   );

   modport slave (
      input  in_sync, in_i, in_q,
      output out_i, out_q, out_valid, out_ch, out_sync, sync_err
   );
endinterface

// File: rtl/chan_sel_bin_extract.sv
// Extracts one channel per frame from a channelized I/Q stream. The channel
// comes from the ch_bin register word and is latched only at frame sync.
module chan_sel_bin_extract #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned N_LANES = 4,
   parameter int unsigned N_CYC   = 256,
   parameter int unsigned CH_W    = 10
) (
   input  logic                  user_clk,
   input  logic                  user_rst_n,
   input  logic [31:0]           ch_bin,
   chan_sel_bin_extract_if.slave bus
);
   localparam int unsigned LANE_W = $clog2(N_LANES);
   localparam int unsigned CYC_W  = $clog2(N_CYC);
   localparam int unsigned BUS_W  = N_LANES * DATA_W;
   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(N_CYC - 1);

   logic [CYC_W-1:0]  cyc_cnt;
   logic              armed;
   logic [CH_W-1:0]   sel_ch;
   logic              sel_en;

   logic [BUS_W-1:0]  s1_i;
   logic [BUS_W-1:0]  s1_q;
   logic              s1_hit;
   logic [LANE_W-1:0] s1_lane;
   logic [CH_W-1:0]   s1_ch;
   logic              sync_d1;

   logic [CYC_W-1:0]  sel_cyc_c;
   logic [LANE_W-1:0] sel_lane_c;
   logic              hit_c;
   logic [DATA_W-1:0] lane_i_c;
   logic [DATA_W-1:0] lane_q_c;
   logic              unused_ch_bits;

   assign unused_ch_bits = ^ch_bin[30:CH_W];

   // Channel decode: upper bits pick the frame cycle, lower bits the lane
   assign sel_cyc_c  = sel_ch[CH_W-1:LANE_W];
   assign sel_lane_c = sel_ch[LANE_W-1:0];
   assign hit_c      = armed & sel_en & (cyc_cnt == sel_cyc_c);

   // Frame counter, sync alignment check and register capture at sync
   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         cyc_cnt      <= CYC_LAST;
         armed        <= 1'b0;
         sel_ch       <= '0;
         sel_en       <= 1'b0;
         bus.sync_err <= 1'b0;
      end else begin
         if (bus.in_sync) begin
            cyc_cnt <= '0;
            armed   <= 1'b1;
            sel_ch  <= ch_bin[CH_W-1:0];
            sel_en  <= ch_bin[31];
            if (armed && (cyc_cnt != CYC_LAST))
               bus.sync_err <= 1'b1;
         end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
         end
      end
   end

   // Stage 1: capture all lanes plus the hit decision made with the current selection
   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         s1_i    <= '0;
         s1_q    <= '0;
         s1_hit  <= 1'b0;
         s1_lane <= '0;
         s1_ch   <= '0;
      end else begin
         s1_i    <= bus.in_i;
         s1_q    <= bus.in_q;
         s1_hit  <= hit_c;
         s1_lane <= sel_lane_c;
         s1_ch   <= sel_ch;
      end
   end

   // Lane mux for stage 2
   always_comb begin
      lane_i_c = s1_i[DATA_W-1:0];
      lane_q_c = s1_q[DATA_W-1:0];
      for (int l = 0; l < int'(N_LANES); l++) begin
         if (s1_lane == LANE_W'(l)) begin
            lane_i_c = s1_i[l*DATA_W +: DATA_W];
            lane_q_c = s1_q[l*DATA_W +: DATA_W];
         end
      end
   end

   // Stage 2: outputs update only on a hit and hold otherwise
   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         bus.out_i     <= '0;
         bus.out_q     <= '0;
         bus.out_ch    <= '0;
         bus.out_valid <= 1'b0;
      end else begin
         bus.out_valid <= s1_hit;
         if (s1_hit) begin
            bus.out_i  <= lane_i_c;
            bus.out_q  <= lane_q_c;
            bus.out_ch <= s1_ch;
         end
      end
   end

   // Sync delayed to line up with the two pipeline stages
   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         sync_d1      <= 1'b0;
         bus.out_sync <= 1'b0;
      end else begin
         sync_d1      <= bus.in_sync;
         bus.out_sync <= sync_d1;
      end
   end
endmodule

// File: tb/tb_chan_sel_bin_extract.sv
// Directed bench for chan_sel_bin_extract with a queue-based scoreboard.
module tb_chan_sel_bin_extract;
   localparam int unsigned DATA_W  = 16;
   localparam int unsigned N_LANES = 4;
   localparam int unsigned N_CYC   = 256;
   localparam int unsigned CH_W    = 10;

   typedef struct {
      int          due;
      logic [15:0] i;
      logic [15:0] q;
      logic [9:0]  ch;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] ch_bin = '0;
   int          n = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   int          fpos = 0;
   logic        prev_sync = 1'b0;
   int          s;
   exp_t        sb[$];

   chan_sel_bin_extract_if #(.DATA_W(DATA_W), .N_LANES(N_LANES), .CH_W(CH_W)) bus ();

   chan_sel_bin_extract #(
      .DATA_W(DATA_W), .N_LANES(N_LANES), .N_CYC(N_CYC), .CH_W(CH_W)
   ) dut (
      .user_clk  (clk),
      .user_rst_n(rst_n),
      .ch_bin    (ch_bin),
      .bus       (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) n <= n + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", name, n, got, exp);
      end
   endtask

   task automatic push(input int due, input int ch);
      exp_t e;
      e.due = due;
      e.i   = 16'(ch);
      e.q   = 16'h8000 | 16'(ch);
      e.ch  = 10'(ch);
      sb.push_back(e);
   endtask

   // One clock: drive sync and lane data (lane value = channel index at this frame position)
   task automatic cycle(input logic sync);
      @(posedge clk);
      #1;
      fpos = prev_sync ? 0 : (fpos + 1) % int'(N_CYC);
      prev_sync = sync;
      bus.in_sync = sync;
      for (int l = 0; l < int'(N_LANES); l++) begin
         bus.in_i[l*16 +: 16] = 16'(fpos * int'(N_LANES) + l);
         bus.in_q[l*16 +: 16] = 16'h8000 | 16'(fpos * int'(N_LANES) + l);
      end
   endtask

   task automatic run(input int k);
      for (int j = 0; j < k; j++) cycle(1'b0);
   endtask

   // Monitor: every presented output pops the scoreboard; overdue entries count as missing
   always @(negedge clk) begin
      if (bus.out_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", 32'(bus.out_valid), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("valid_cycle", 32'(n), 32'(e.due));
            chk("out_i", 32'(bus.out_i), 32'(e.i));
            chk("out_q", 32'(bus.out_q), 32'(e.q));
            chk("out_ch", 32'(bus.out_ch), 32'(e.ch));
         end
      end else if (sb.size() != 0 && sb[0].due < n) begin
         chk("missing_valid", 32'(bus.out_valid), 32'd1);
         void'(sb.pop_front());
      end
   end

   initial begin
      bus.in_sync = 1'b0;
      bus.in_i    = '0;
      bus.in_q    = '0;

      // Reset values
      run(3);
      @(negedge clk);
      chk("rst_valid", 32'(bus.out_valid), 0);
      chk("rst_out_i", 32'(bus.out_i), 0);
      chk("rst_out_ch", 32'(bus.out_ch), 0);
      chk("rst_sync_err", 32'(bus.sync_err), 0);
      rst_n = 1'b1;

      // Data without sync: nothing comes out
      run(300);
      @(negedge clk);
      chk("nosync_out_i", 32'(bus.out_i), 0);
      chk("nosync_out_q", 32'(bus.out_q), 0);
      chk("nosync_out_sync", 32'(bus.out_sync), 0);
      chk("nosync_sync_err", 32'(bus.sync_err), 0);

      // Channel 5 enabled; hit at frame cycle 1, two cycles of latency
      ch_bin = 32'h8000_0005;
      cycle(1'b1);
      s = n;
      push(s + 4, 5);
      run(255);
      cycle(1'b0);                    // frame cycle 255, no sync: free-running wrap
      ch_bin = 32'h8000_03FF;         // mid-frame write, must not affect this frame
      cycle(1'b0);                    // frame cycle 0 of second frame
      push(s + 260, 5);
      run(254);
      cycle(1'b1);                    // aligned sync at frame cycle 255 latches ch 1023
      s = n;
      push(s + 258, 1023);
      run(255);
      ch_bin = 32'h8000_0005;
      cycle(1'b1);                    // sync coincides with the ch 1023 hit
      s = n;
      push(s + 4, 5);
      cycle(1'b0);
      @(negedge clk);
      chk("aligned_sync_err", 32'(bus.sync_err), 0);

      // Early sync at cyc_cnt = 100
      run(99);
      cycle(1'b1);
      @(negedge clk);
      chk("early_pre_err", 32'(bus.sync_err), 0);
      s = n;
      push(s + 4, 5);
      cycle(1'b0);
      @(negedge clk);
      chk("early_sync_err", 32'(bus.sync_err), 1);

      // Enable cleared at the next aligned sync; out_sync still pulses
      run(254);
      ch_bin = 32'h0000_0005;
      cycle(1'b1);
      s = n;
      cycle(1'b0);
      @(negedge clk);
      chk("out_sync_d1", 32'(bus.out_sync), 0);
      cycle(1'b0);
      @(negedge clk);
      chk("out_sync_d2", 32'(bus.out_sync), 1);
      cycle(1'b0);
      @(negedge clk);
      chk("out_sync_d3", 32'(bus.out_sync), 0);
      chk("sticky_sync_err", 32'(bus.sync_err), 1);
      run(300);
      @(negedge clk);
      chk("hold_out_i", 32'(bus.out_i), 5);

      // Reset mid-frame: outputs clear at once, nothing until next sync
      cycle(1'b0);
      rst_n = 1'b0;
      #2;
      chk("midrst_out_i", 32'(bus.out_i), 0);
      chk("midrst_out_ch", 32'(bus.out_ch), 0);
      chk("midrst_sync_err", 32'(bus.sync_err), 0);
      run(2);
      rst_n = 1'b1;
      ch_bin = 32'h8000_0005;
      run(300);
      cycle(1'b1);
      s = n;
      push(s + 4, 5);
      run(10);
      @(negedge clk);
      chk("post_rst_sync_err", 32'(bus.sync_err), 0);
      chk("scoreboard_empty", 32'(sb.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
